// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle CPU controller: the state encoding,
// the opcodes it decodes, and the select codes it drives toward the ALU
// controller, the ALU B-operand mux and the PC-source mux.
package mcycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_BNEEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JEX    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // aluop codes understood by the external ALU controller
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

    // next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Width of an index covering 0..n-1; kept at least 1 bit so a
    // single-beat (32-bit memory) build still has a legal vector.
    function automatic int beat_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
//   master : the controller; samples op/zero/memready, drives all strobes
//   slave  : the datapath/memory side
// NBEATS sets the width of irwrite (one enable per instruction-register lane).
interface mcycle_controller_if #(
    parameter int NBEATS = 4
);

    logic [5:0]        op;
    logic              zero;
    logic              memready;

    logic              memread;
    logic              memwrite;
    logic              alusrca;
    logic              memtoreg;
    logic              lord;
    logic              regwrite;
    logic              regdst;
    logic              pcen;
    logic [1:0]        pcsource;
    logic [1:0]        alusrcb;
    logic [1:0]        aluop;
    logic [NBEATS-1:0] irwrite;
    logic              illegal;

    modport master (
        input  op, zero, memready,
        output memread, memwrite, alusrca, memtoreg, lord, regwrite, regdst,
               pcen, pcsource, alusrcb, aluop, irwrite, illegal
    );

    modport slave (
        output op, zero, memready,
        input  memread, memwrite, alusrca, memtoreg, lord, regwrite, regdst,
               pcen, pcsource, alusrcb, aluop, irwrite, illegal
    );

endinterface

// File: rtl/fetch_beat_counter.sv
// Instruction-fetch beat index.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : a fetch beat completes this cycle
//   beat       : current beat index, 0..NBEATS-1
//   last       : current beat is the final one; the next completed beat wraps
module fetch_beat_counter
    import mcycle_pkg::*;
#(
    parameter int NBEATS = 4,
    localparam int BW    = beat_width(NBEATS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          last
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    logic [BW-1:0] beat_q;
    logic [BW-1:0] beat_d;

    always_comb begin
        beat_d = beat_q;
        if (en) begin
            beat_d = last ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    assign last = (beat_q == LAST_BEAT);

endmodule

// File: rtl/mcycle_controller.sv
// Multi-cycle CPU main controller. Fetches a 32-bit instruction in
// 32/WIDTH memory beats, then sequences the datapath through the
// execute states for lw, sw, R-type, beq, bne, addi and j.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mcycle_controller_if master (op/zero/memready in,
//                memory strobes, datapath selects, irwrite, illegal out)
// Outputs are a pure decode of state, fetch beat, memready and zero, and
// are held at 0 while reset is asserted.
//
// state    | meaning
// FETCH    | read instruction beat fb; latch lane, advance PC on memready
// DECODE   | compute branch target; dispatch on op
// MEMADR   | compute load/store address
// MEMRD    | load read, wait for memready
// MEMWB    | write loaded data to rt
// MEMWR    | store write, wait for memready
// RTEX     | R-type ALU operation
// RTWB     | write ALU result to rd
// BEQEX    | compare; take branch on zero
// BNEEX    | compare; take branch on not zero
// ADDIEX   | add immediate
// ADDIWB   | write ALU result to rt
// JEX      | load jump target into PC
module mcycle_controller
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mcycle_controller_if.master  bus
);

    localparam int NBEATS = 32 / WIDTH;
    localparam int BEAT_W = beat_width(NBEATS);

    state_e state_q;
    state_e state_d;

    logic [BEAT_W-1:0] beat;
    logic              beat_last;
    logic              beat_en;

    logic              memread_d;
    logic              memwrite_d;
    logic              alusrca_d;
    logic              memtoreg_d;
    logic              lord_d;
    logic              regwrite_d;
    logic              regdst_d;
    logic              pcen_d;
    logic [1:0]        pcsource_d;
    logic [1:0]        alusrcb_d;
    logic [1:0]        aluop_d;
    logic [NBEATS-1:0] irwrite_d;
    logic              illegal_d;

    fetch_beat_counter #(
        .NBEATS (NBEATS)
    ) u_fetch_beat_counter (
        .clk   (clk),
        .reset (reset),
        .en    (beat_en),
        .beat  (beat),
        .last  (beat_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_en    = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        alusrca_d  = 1'b0;
        memtoreg_d = 1'b0;
        lord_d     = 1'b0;
        regwrite_d = 1'b0;
        regdst_d   = 1'b0;
        pcen_d     = 1'b0;
        pcsource_d = PCSRC_ALU;
        alusrcb_d  = ALUSRCB_REG;
        aluop_d    = ALUOP_ADD;
        irwrite_d  = '0;
        illegal_d  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                memread_d = 1'b1;
                alusrcb_d = ALUSRCB_FOUR;
                if (bus.memready) begin
                    irwrite_d = NBEATS'(1) << beat;
                    pcen_d    = 1'b1;
                    beat_en   = 1'b1;
                    if (beat_last) begin
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alusrcb_d = ALUSRCB_BRANCH;
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = ALUSRCB_IMM;
                state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread_d = 1'b1;
                lord_d    = 1'b1;
                if (bus.memready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memwrite_d = 1'b1;
                lord_d     = 1'b1;
                if (bus.memready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEX: begin
                alusrca_d = 1'b1;
                aluop_d   = ALUOP_FUNCT;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca_d  = 1'b1;
                aluop_d    = ALUOP_SUB;
                pcsource_d = PCSRC_ALUOUT;
                pcen_d     = (state_q == S_BEQEX) ? bus.zero : ~bus.zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_d = 1'b1;
                alusrcb_d = ALUSRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_d = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsource_d = PCSRC_JUMP;
                pcen_d     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every strobe, including a decode-time illegal pulse
        // or a fetch beat that would otherwise land this cycle.
        if (reset) begin
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            alusrca_d  = 1'b0;
            memtoreg_d = 1'b0;
            lord_d     = 1'b0;
            regwrite_d = 1'b0;
            regdst_d   = 1'b0;
            pcen_d     = 1'b0;
            pcsource_d = '0;
            alusrcb_d  = '0;
            aluop_d    = '0;
            irwrite_d  = '0;
            illegal_d  = 1'b0;
        end
    end

    assign bus.memread  = memread_d;
    assign bus.memwrite = memwrite_d;
    assign bus.alusrca  = alusrca_d;
    assign bus.memtoreg = memtoreg_d;
    assign bus.lord     = lord_d;
    assign bus.regwrite = regwrite_d;
    assign bus.regdst   = regdst_d;
    assign bus.pcen     = pcen_d;
    assign bus.pcsource = pcsource_d;
    assign bus.alusrcb  = alusrcb_d;
    assign bus.aluop    = aluop_d;
    assign bus.irwrite  = irwrite_d;
    assign bus.illegal  = illegal_d;

endmodule

// File: tb/tb_mcycle_controller.sv
// Directed bench for mcycle_controller at WIDTH 8, 16 and 32.
// Control word layout used for expectations (15 bits, MSB first):
//   memread memwrite alusrca memtoreg lord regwrite regdst pcen
//   pcsource[1:0] alusrcb[1:0] aluop[1:0] illegal
module tb_mcycle_controller;

    localparam logic [14:0] E_ZERO  = 15'b0;
    localparam logic [14:0] E_FWAIT = {8'b10000000, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_FBEAT = {8'b10000001, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_DEC   = {8'b00000000, 2'b00, 2'b11, 2'b00, 1'b0};
    localparam logic [14:0] E_ILL   = {8'b00000000, 2'b00, 2'b11, 2'b00, 1'b1};
    localparam logic [14:0] E_MADR  = {8'b00100000, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_MRD   = {8'b10001000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MWB   = {8'b00010100, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MWR   = {8'b01001000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_RTEX  = {8'b00100000, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_RTWB  = {8'b00000110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_BR_T  = {8'b00100001, 2'b01, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_BR_N  = {8'b00100000, 2'b01, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_ADDEX = {8'b00100000, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_ADDWB = {8'b00000100, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_JEX   = {8'b00000001, 2'b10, 2'b00, 2'b00, 1'b0};

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        bit          rst;
        logic [5:0]  op;
        bit          zero;
        bit          mr;
        logic [14:0] ctl;
        logic [3:0]  ir;
        string       name;
    } vec_t;

    logic clk;
    logic rst8, rst16, rst32;
    int   n_checks;
    int   n_fail;
    vec_t vt[$];

    mcycle_controller_if #(.NBEATS(4)) if8  ();
    mcycle_controller_if #(.NBEATS(2)) if16 ();
    mcycle_controller_if #(.NBEATS(1)) if32 ();

    mcycle_controller #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(if8.master));
    mcycle_controller #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(if16.master));
    mcycle_controller #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(if32.master));

    logic [14:0] a8, a16, a32;
    assign a8  = {if8.memread, if8.memwrite, if8.alusrca, if8.memtoreg, if8.lord,
                  if8.regwrite, if8.regdst, if8.pcen, if8.pcsource, if8.alusrcb,
                  if8.aluop, if8.illegal};
    assign a16 = {if16.memread, if16.memwrite, if16.alusrca, if16.memtoreg, if16.lord,
                  if16.regwrite, if16.regdst, if16.pcen, if16.pcsource, if16.alusrcb,
                  if16.aluop, if16.illegal};
    assign a32 = {if32.memread, if32.memwrite, if32.alusrca, if32.memtoreg, if32.lord,
                  if32.regwrite, if32.regdst, if32.pcen, if32.pcsource, if32.alusrcb,
                  if32.aluop, if32.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input bit rst, input logic [5:0] op, input bit z,
                                input bit mr, input logic [14:0] ctl,
                                input logic [3:0] ir, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = z; v.mr = mr;
        v.ctl = ctl; v.ir = ir; v.name = name;
        vt.push_back(v);
    endfunction

    // Drive one cycle of inputs to the selected DUT, check its decode
    // mid-cycle, then advance past the next rising edge.
    task automatic step(input int dut, input bit rst, input logic [5:0] op,
                        input bit z, input bit mr, input logic [14:0] e_ctl,
                        input logic [3:0] e_ir, input string name);
        logic [14:0] act_ctl;
        logic [3:0]  act_ir;
        case (dut)
            8:  begin rst8  = rst; if8.op  = op; if8.zero  = z; if8.memready  = mr; end
            16: begin rst16 = rst; if16.op = op; if16.zero = z; if16.memready = mr; end
            default: begin rst32 = rst; if32.op = op; if32.zero = z; if32.memready = mr; end
        endcase
        #1;
        case (dut)
            8:  begin act_ctl = a8;  act_ir = if8.irwrite; end
            16: begin act_ctl = a16; act_ir = {2'b00, if16.irwrite}; end
            default: begin act_ctl = a32; act_ir = {3'b000, if32.irwrite}; end
        endcase
        n_checks++;
        if (act_ctl !== e_ctl || act_ir !== e_ir) begin
            n_fail++;
            $display("FAIL %s (w%0d): got ctl=%b irwrite=%b, want ctl=%b irwrite=%b",
                     name, dut, act_ctl, act_ir, e_ctl, e_ir);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst8 = 1'b1; rst16 = 1'b1; rst32 = 1'b1;
        if8.op  = '0; if8.zero  = 1'b0; if8.memready  = 1'b0;
        if16.op = '0; if16.zero = 1'b0; if16.memready = 1'b0;
        if32.op = '0; if32.zero = 1'b0; if32.memready = 1'b0;

        // WIDTH=8 table
        add(1, RT,   0, 1, E_ZERO,  4'b0000, "reset_outputs");
        add(0, RT,   0, 1, E_FBEAT, 4'b0001, "rt_f0");
        add(0, RT,   0, 1, E_FBEAT, 4'b0010, "rt_f1");
        add(0, RT,   0, 1, E_FBEAT, 4'b0100, "rt_f2");
        add(0, RT,   0, 1, E_FBEAT, 4'b1000, "rt_f3");
        add(0, RT,   0, 1, E_DEC,   4'b0000, "rt_decode");
        add(0, RT,   0, 1, E_RTEX,  4'b0000, "rt_ex");
        add(0, RT,   0, 1, E_RTWB,  4'b0000, "rt_wb");
        add(0, LW,   0, 1, E_FBEAT, 4'b0001, "lw_f0");
        add(0, LW,   0, 0, E_FWAIT, 4'b0000, "lw_f1_wait_a");
        add(0, LW,   0, 0, E_FWAIT, 4'b0000, "lw_f1_wait_b");
        add(0, LW,   0, 1, E_FBEAT, 4'b0010, "lw_f1");
        add(0, LW,   0, 1, E_FBEAT, 4'b0100, "lw_f2");
        add(0, LW,   0, 1, E_FBEAT, 4'b1000, "lw_f3");
        add(0, LW,   0, 1, E_DEC,   4'b0000, "lw_decode");
        add(0, LW,   0, 1, E_MADR,  4'b0000, "lw_memadr");
        add(0, LW,   0, 0, E_MRD,   4'b0000, "lw_memrd_wait_a");
        add(0, LW,   0, 0, E_MRD,   4'b0000, "lw_memrd_wait_b");
        add(0, LW,   0, 0, E_MRD,   4'b0000, "lw_memrd_wait_c");
        add(0, LW,   0, 1, E_MRD,   4'b0000, "lw_memrd_done");
        add(0, LW,   0, 1, E_MWB,   4'b0000, "lw_memwb");
        add(0, BAD,  0, 1, E_FBEAT, 4'b0001, "bad_f0");
        add(0, BAD,  0, 1, E_FBEAT, 4'b0010, "bad_f1");
        add(0, BAD,  0, 1, E_FBEAT, 4'b0100, "bad_f2");
        add(0, BAD,  0, 1, E_FBEAT, 4'b1000, "bad_f3");
        add(0, BAD,  0, 1, E_ILL,   4'b0000, "bad_illegal");
        add(0, ADDI, 0, 1, E_FBEAT, 4'b0001, "after_illegal_f0");
        add(0, ADDI, 0, 1, E_FBEAT, 4'b0010, "addi_f1");
        add(0, ADDI, 0, 1, E_FBEAT, 4'b0100, "addi_f2");
        add(0, ADDI, 0, 1, E_FBEAT, 4'b1000, "addi_f3");
        add(0, ADDI, 0, 1, E_DEC,   4'b0000, "addi_decode");
        add(0, ADDI, 0, 1, E_ADDEX, 4'b0000, "addi_ex");
        add(0, ADDI, 0, 1, E_ADDWB, 4'b0000, "addi_wb");
        add(0, JMP,  0, 1, E_FBEAT, 4'b0001, "j_f0");
        add(0, JMP,  0, 1, E_FBEAT, 4'b0010, "j_f1");
        add(0, JMP,  0, 1, E_FBEAT, 4'b0100, "j_f2");
        add(0, JMP,  0, 1, E_FBEAT, 4'b1000, "j_f3");
        add(0, JMP,  0, 1, E_DEC,   4'b0000, "j_decode");
        add(0, JMP,  0, 1, E_JEX,   4'b0000, "j_ex");
        add(0, LW,   0, 1, E_FBEAT, 4'b0001, "rlw_f0");
        add(0, LW,   0, 1, E_FBEAT, 4'b0010, "rlw_f1");
        add(0, LW,   0, 1, E_FBEAT, 4'b0100, "rlw_f2");
        add(0, LW,   0, 1, E_FBEAT, 4'b1000, "rlw_f3");
        add(0, LW,   0, 1, E_DEC,   4'b0000, "rlw_decode");
        add(0, LW,   0, 1, E_MADR,  4'b0000, "rlw_memadr");
        add(0, LW,   0, 0, E_MRD,   4'b0000, "rlw_memrd_wait");
        add(1, LW,   0, 1, E_ZERO,  4'b0000, "reset_in_memrd");
        add(0, LW,   0, 1, E_FBEAT, 4'b0001, "post_reset_f0");
        add(0, LW,   0, 1, E_FBEAT, 4'b0010, "post_reset_f1");
        add(1, LW,   0, 1, E_ZERO,  4'b0000, "reset_in_fetch_beat2");
        add(0, LW,   0, 1, E_FBEAT, 4'b0001, "post_reset2_f0");
        add(0, LW,   0, 0, E_FWAIT, 4'b0000, "post_reset2_f1_wait");

        @(posedge clk);
        #1;
        for (int i = 0; i < vt.size(); i++) begin
            step(8, vt[i].rst, vt[i].op, vt[i].zero, vt[i].mr, vt[i].ctl, vt[i].ir, vt[i].name);
        end
        rst8 = 1'b1;

        // WIDTH=32: single-beat fetch, beq taken then not taken
        step(32, 1, BEQ, 1, 1, E_ZERO,  4'b0000, "w32_reset");
        step(32, 0, BEQ, 1, 1, E_FBEAT, 4'b0001, "w32_beq_fetch");
        step(32, 0, BEQ, 1, 1, E_DEC,   4'b0000, "w32_beq_decode");
        step(32, 0, BEQ, 1, 1, E_BR_T,  4'b0000, "w32_beq_taken");
        step(32, 0, BEQ, 0, 1, E_FBEAT, 4'b0001, "w32_beq2_fetch");
        step(32, 0, BEQ, 0, 1, E_DEC,   4'b0000, "w32_beq2_decode");
        step(32, 0, BEQ, 0, 1, E_BR_N,  4'b0000, "w32_beq_not_taken");
        step(32, 0, BEQ, 0, 0, E_FWAIT, 4'b0000, "w32_back_to_fetch");
        rst32 = 1'b1;

        // WIDTH=16: bne both ways, then a store with a memory wait
        step(16, 1, BNE, 0, 1, E_ZERO,  4'b0000, "w16_reset");
        step(16, 0, BNE, 0, 1, E_FBEAT, 4'b0001, "w16_bne_f0");
        step(16, 0, BNE, 0, 1, E_FBEAT, 4'b0010, "w16_bne_f1");
        step(16, 0, BNE, 0, 1, E_DEC,   4'b0000, "w16_bne_decode");
        step(16, 0, BNE, 0, 1, E_BR_T,  4'b0000, "w16_bne_taken");
        step(16, 0, BNE, 1, 1, E_FBEAT, 4'b0001, "w16_bne2_f0");
        step(16, 0, BNE, 1, 1, E_FBEAT, 4'b0010, "w16_bne2_f1");
        step(16, 0, BNE, 1, 1, E_DEC,   4'b0000, "w16_bne2_decode");
        step(16, 0, BNE, 1, 1, E_BR_N,  4'b0000, "w16_bne_not_taken");
        step(16, 0, SW,  0, 1, E_FBEAT, 4'b0001, "w16_sw_f0");
        step(16, 0, SW,  0, 1, E_FBEAT, 4'b0010, "w16_sw_f1");
        step(16, 0, SW,  0, 1, E_DEC,   4'b0000, "w16_sw_decode");
        step(16, 0, SW,  0, 1, E_MADR,  4'b0000, "w16_sw_memadr");
        step(16, 0, SW,  0, 0, E_MWR,   4'b0000, "w16_sw_wait_a");
        step(16, 0, SW,  0, 0, E_MWR,   4'b0000, "w16_sw_wait_b");
        step(16, 0, SW,  0, 1, E_MWR,   4'b0000, "w16_sw_done");
        step(16, 0, SW,  0, 0, E_FWAIT, 4'b0000, "w16_sw_back_to_fetch");
        rst16 = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_controller.md
MCYCLE_CONTROLLER -- requirements
Module: mcycle_controller

Interface
REQ-001 Parameter WIDTH, default 8: memory data width in bits; legal values 8, 16 and 32.
REQ-002 Derived constant NBEATS = 32/WIDTH: number of instruction-fetch beats.
REQ-003 clk  input  1  system clock; every flop updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  6  opcode field, instr[31:26].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 memready  input  1  memory beat complete; new handshake.
REQ-008 memread, memwrite  output  1 each  memory strobes.
REQ-009 alusrca, memtoreg, lord, regwrite, regdst, pcen  output  1 each  datapath controls.
REQ-010 pcsource, alusrcb, aluop  output  2 each  datapath and ALU-controller selects.
REQ-011 irwrite  output  NBEATS  one-hot instruction-register byte-lane write enable.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX.
REQ-014 FETCH: beat counter fb selects the beat, range 0..NBEATS-1; memread=1, lord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-015 FETCH with memready=1: irwrite bit fb=1, pcen=1, and fb increments; on the last beat fb wraps to 0 and the next state is DECODE.
REQ-016 FETCH with memready=0: irwrite=0, pcen=0; state and fb hold.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00; lasts 1 cycle.
REQ-018 Transitions from DECODE by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEX
  - 000100 -> BEQEX
  - 000101 -> BNEEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other op -> FETCH, with illegal=1 for that cycle.
REQ-019 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD when op=100011, otherwise MEMWR.
REQ-020 MEMRD: memread=1, lord=1; holds until memready=1, then goes to MEMWB.
REQ-021 MEMWB: regwrite=1, memtoreg=1, regdst=0; next state FETCH.
REQ-022 MEMWR: memwrite=1, lord=1; holds until memready=1, then goes to FETCH.
REQ-023 RTEX: alusrca=1, alusrcb=00, aluop=10; next state RTWB.
REQ-024 RTWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
REQ-025 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01; pcen=zero; next state FETCH.
REQ-026 BNEEX: same controls as BEQEX except pcen=~zero.
REQ-027 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB.
REQ-028 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
REQ-029 JEX: pcsource=10, pcen=1; next state FETCH.
REQ-030 Every output not listed for a state is 0 in that state.
REQ-031 Outputs are a combinational decode of state, fb, memready and zero.
REQ-032 op is sampled only in DECODE and MEMADR.

Reset
REQ-033 reset=1 at a clock edge: state=FETCH and fb=0, from any state, including mid-fetch or mid-memory-wait.
REQ-034 While reset=1, every output is forced to 0, including illegal and irwrite.
REQ-035 First cycle after reset deasserts: FETCH beat 0.

Structure
REQ-036 Shared package mcycle_pkg holds the opcode constants, the state encoding, and the aluop, alusrcb and pcsource codes.
REQ-037 Sub-module fetch_beat_counter is parameterised by NBEATS, has inputs clk, reset, en and outputs beat and last.
REQ-038 The existing ALU controller is reused unchanged and is not instantiated inside this block.

Verification
REQ-039 WIDTH=8, memready=1, op=000000: irwrite sequence 0001, 0010, 0100, 1000; then DECODE, RTEX (aluop=10), RTWB (regwrite=1, regdst=1); 7 cycles total.
REQ-040 WIDTH=8, op=100011, memready=0 for 2 cycles on fetch beat 1 and for 3 cycles in MEMRD: irwrite and pcen stay 0 while waiting; MEMWB (memtoreg=1, regwrite=1) occurs exactly once.
REQ-041 WIDTH=32, op=000100: single fetch beat with irwrite=1; zero=1 -> pcen=1, pcsource=01 in BEQEX; repeat with zero=0 -> pcen=0.
REQ-042 WIDTH=16, op=000101 with zero=0 -> pcen=1; op=101011 -> memwrite=1, lord=1 until memready=1.
REQ-043 op=111111: illegal=1 for exactly 1 cycle in DECODE, then FETCH beat 0, with no regwrite, memwrite or pcen in between.
REQ-044 reset=1 asserted in MEMRD and again in fetch beat 2: all outputs 0 during reset; after release, FETCH beat 0 with irwrite=0001.
